// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm: breathing LED driver. An 8-bit brightness level ramps
// 0 -> 255 -> 0 continuously and is rendered on LED7 by a 256-clock PWM.
// LED6..LED0 are held off.
// Optional build macro: LED_BREATHE_GAMMA_EN. When defined, the PWM duty is the
// squared level (upper byte of level*level); when undefined, the duty is the
// linear level and no multiplier exists.
module led_breathe_pwm #(
    parameter int unsigned STEP_DIV = 23438
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    output logic       LED7,
    output logic       LED6,
    output logic       LED5,
    output logic       LED4,
    output logic       LED3,
    output logic       LED2,
    output logic       LED1,
    output logic       LED0,
    output logic [7:0] LEVEL
);

    localparam logic [0:0]  ST_UP      = 1'b0;
    localparam logic [0:0]  ST_DOWN    = 1'b1;
    localparam logic [23:0] PRESC_LAST = 24'(STEP_DIV - 32'd1);

    logic [7:0]  pwm_cnt_r;
    logic [23:0] presc_r;
    logic [7:0]  level_r;
    logic [0:0]  state_r;
    logic [7:0]  duty_r;
    logic        led7_r;

    logic        step_s;
    logic        latch_s;
    logic [7:0]  level_nxt_s;
    logic [0:0]  state_nxt_s;
    logic [7:0]  duty_src_s;

`ifdef LED_BREATHE_GAMMA_EN
    // Perceptual brightness: upper byte of the 16-bit square of the level.
    function automatic logic [7:0] gamma_f(input logic [7:0] lin);
        logic [15:0] sq;
        sq = {8'd0, lin} * {8'd0, lin};
        return sq[15:8];
    endfunction
`endif

    // Brightness-step strobe and end-of-PWM-period duty latch strobe.
    always_comb begin
        step_s  = 1'b0;
        latch_s = 1'b0;
        if (EN) begin
            step_s  = (presc_r == PRESC_LAST);
            latch_s = (pwm_cnt_r == 8'd255);
        end else begin
            step_s  = 1'b0;
            latch_s = 1'b0;
        end
    end

    // Ramp next-state: each endpoint is held for exactly one step.
    always_comb begin
        level_nxt_s = level_r;
        state_nxt_s = state_r;
        if (step_s) begin
            case (state_r)
                ST_UP: begin
                    if (level_r == 8'd255) begin
                        level_nxt_s = 8'd254;
                        state_nxt_s = ST_DOWN;
                    end else begin
                        level_nxt_s = level_r + 8'd1;
                    end
                end
                ST_DOWN: begin
                    if (level_r == 8'd0) begin
                        level_nxt_s = 8'd1;
                        state_nxt_s = ST_UP;
                    end else begin
                        level_nxt_s = level_r - 8'd1;
                    end
                end
                default: begin
                    level_nxt_s = 8'd0;
                    state_nxt_s = ST_UP;
                end
            endcase
        end else begin
            level_nxt_s = level_r;
            state_nxt_s = state_r;
        end
    end

    // Duty source: linear level or its gamma-corrected value.
    always_comb begin
        duty_src_s = level_r;
`ifdef LED_BREATHE_GAMMA_EN
        duty_src_s = gamma_f(level_r);
`else
        duty_src_s = level_r;
`endif
    end

    // Free-running PWM counter, advances only while enabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm_cnt_r <= 8'd0;
        end else if (EN) begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Step prescaler counting 0..STEP_DIV-1 while enabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_r <= 24'd0;
        end else if (step_s) begin
            presc_r <= 24'd0;
        end else if (EN) begin
            presc_r <= presc_r + 24'd1;
        end else begin
            presc_r <= presc_r;
        end
    end

    // Ramp level and direction registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_r <= 8'd0;
            state_r <= ST_UP;
        end else begin
            level_r <= level_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    // Duty latch on the last cycle of a PWM period; samples the pre-step level.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            duty_r <= 8'd0;
        end else if (latch_s) begin
            duty_r <= duty_src_s;
        end else begin
            duty_r <= duty_r;
        end
    end

    // Registered PWM compare; dark whenever disabled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            led7_r <= 1'b0;
        end else begin
            led7_r <= EN & (pwm_cnt_r < duty_r);
        end
    end

    assign LED7  = led7_r;
    assign LED6  = 1'b0;
    assign LED5  = 1'b0;
    assign LED4  = 1'b0;
    assign LED3  = 1'b0;
    assign LED2  = 1'b0;
    assign LED1  = 1'b0;
    assign LED0  = 1'b0;
    assign LEVEL = level_r;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Testbench for led_breathe_pwm. Instance A uses STEP_DIV=4 for ramp, PWM,
// reset and enable scenarios; instance B uses STEP_DIV=256 so that even
// levels (0, 64, 128) get latched as duty. Outputs are sampled on the
// falling clock edge. Works in both the linear and LED_BREATHE_GAMMA_EN builds.
module tb_led_breathe_pwm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0;
    logic       en_a  = 1'b0;
    logic       rst_b = 1'b0;
    logic       en_b  = 1'b0;
    logic [7:0] led_a;
    logic [7:0] led_b;
    logic [7:0] level_a;
    logic [7:0] level_b;

    int   errors = 0;
    int   checks = 0;
    logic other_bad = 1'b0;

    led_breathe_pwm #(.STEP_DIV(4)) dut_a (
        .CLK(clk), .RST(rst_a), .EN(en_a),
        .LED7(led_a[7]), .LED6(led_a[6]), .LED5(led_a[5]), .LED4(led_a[4]),
        .LED3(led_a[3]), .LED2(led_a[2]), .LED1(led_a[1]), .LED0(led_a[0]),
        .LEVEL(level_a)
    );

    led_breathe_pwm #(.STEP_DIV(256)) dut_b (
        .CLK(clk), .RST(rst_b), .EN(en_b),
        .LED7(led_b[7]), .LED6(led_b[6]), .LED5(led_b[5]), .LED4(led_b[4]),
        .LED3(led_b[3]), .LED2(led_b[2]), .LED1(led_b[1]), .LED0(led_b[0]),
        .LEVEL(level_b)
    );

    // Sticky record of any LED6..LED0 activity on either instance.
    always @(negedge clk) begin
        if (led_a[6:0] !== 7'd0 || led_b[6:0] !== 7'd0) other_bad <= 1'b1;
    end

    // Expected duty for a latched level in the current build.
    function automatic logic [7:0] dmap(input logic [7:0] l);
`ifdef LED_BREATHE_GAMMA_EN
        logic [15:0] p;
        p = {8'd0, l} * {8'd0, l};
        return p[15:8];
`else
        return l;
`endif
    endfunction

    // Sample one 256-clock PWM period: count highs and highs outside the prefix.
    task automatic measure_period(input bit use_b, input logic [7:0] exp_d,
                                  output int highs, output int misplaced);
        logic v;
        highs = 0;
        misplaced = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            v = use_b ? led_b[7] : led_a[7];
            if (v === 1'b1) highs++;
            if (v !== (i < int'(exp_d))) misplaced++;
        end
    endtask

    task automatic test_reset;
        logic exp_led;
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #2;
        checks++;
        if ({led_a, level_a} !== 16'd0) begin
            errors++;
            $display("FAIL reset_initial: led=%h level=%0d, expected led=00 level=0", led_a, level_a);
        end
        @(negedge clk);
        rst_a = 1'b0;
        en_a  = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (level_a !== 8'd75) begin
            errors++;
            $display("FAIL reset_prerun_level: got %0d, expected 75", level_a);
        end
        exp_led = (8'd43 < dmap(8'd63));
        checks++;
        if (led_a[7] !== exp_led) begin
            errors++;
            $display("FAIL reset_prerun_led7: got %b, expected %b", led_a[7], exp_led);
        end
        #2;
        rst_a = 1'b1;
        #1;
        checks++;
        if ({led_a, level_a} !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: led=%h level=%0d, expected led=00 level=0 before edge", led_a, level_a);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({led_a, level_a} !== 16'd0) begin
            errors++;
            $display("FAIL reset_held: led=%h level=%0d, expected 0", led_a, level_a);
        end
    endtask

    task automatic test_ramp;
        int ck_k [8] = '{4, 1020, 1023, 1024, 1028, 2040, 2043, 2044};
        int ck_v [8] = '{1, 255, 255, 254, 253, 0, 0, 1};
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        en_a  = 1'b1;
        for (int k = 1; k <= 2044; k++) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                if (k == ck_k[j]) begin
                    checks++;
                    if (level_a !== 8'(ck_v[j])) begin
                        errors++;
                        $display("FAIL ramp_level@%0d: got %0d, expected %0d", k, level_a, ck_v[j]);
                    end
                end
            end
        end
        rst_a = 1'b1;
    endtask

    // Levels change by 64 during each period while the latched duty holds,
    // so the per-period counts also show the update is glitch-free.
    task automatic test_pwm_duty;
        logic [7:0] lat_lvl [8] = '{8'd0, 8'd63, 8'd127, 8'd191, 8'd255, 8'd191, 8'd127, 8'd63};
        logic [7:0] end_lvl [8] = '{8'd64, 8'd128, 8'd192, 8'd254, 8'd190, 8'd126, 8'd62, 8'd2};
        int h;
        int m;
        logic [7:0] d;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        en_a  = 1'b1;
        for (int p = 0; p < 8; p++) begin
            d = dmap(lat_lvl[p]);
            measure_period(1'b0, d, h, m);
            checks++;
            if (h !== int'(d)) begin
                errors++;
                $display("FAIL pwm_count[p%0d]: got %0d high cycles, expected %0d", p, h, d);
            end
            checks++;
            if (m !== 0) begin
                errors++;
                $display("FAIL pwm_contiguous[p%0d]: %0d cycles off the leading block, expected 0", p, m);
            end
            checks++;
            if (level_a !== end_lvl[p]) begin
                errors++;
                $display("FAIL pwm_level_end[p%0d]: got %0d, expected %0d", p, level_a, end_lvl[p]);
            end
        end
        rst_a = 1'b1;
    endtask

    task automatic test_enable_gating;
        logic exp_led;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        en_a  = 1'b1;
        repeat (1641) @(negedge clk);
        checks++;
        if (level_a !== 8'd100) begin
            errors++;
            $display("FAIL gate_level_before: got %0d, expected 100", level_a);
        end
        exp_led = (8'd104 < dmap(8'd127));
        checks++;
        if (led_a[7] !== exp_led) begin
            errors++;
            $display("FAIL gate_led7_before: got %b, expected %b", led_a[7], exp_led);
        end
        en_a = 1'b0;
        @(negedge clk);
        checks++;
        if (led_a[7] !== 1'b0 || level_a !== 8'd100) begin
            errors++;
            $display("FAIL gate_off_1clk: led7=%b level=%0d, expected 0 and 100", led_a[7], level_a);
        end
        repeat (999) @(negedge clk);
        checks++;
        if (led_a[7] !== 1'b0 || level_a !== 8'd100) begin
            errors++;
            $display("FAIL gate_hold: led7=%b level=%0d, expected 0 and 100", led_a[7], level_a);
        end
        en_a = 1'b1;
        @(negedge clk);
        exp_led = (8'd105 < dmap(8'd127));
        checks++;
        if (led_a[7] !== exp_led) begin
            errors++;
            $display("FAIL gate_resume_led7: got %b, expected %b", led_a[7], exp_led);
        end
        @(negedge clk);
        checks++;
        if (level_a !== 8'd100) begin
            errors++;
            $display("FAIL gate_resume_early: got %0d, expected 100 (no early step)", level_a);
        end
        @(negedge clk);
        checks++;
        if (level_a !== 8'd99) begin
            errors++;
            $display("FAIL gate_resume_step: got %0d, expected 99", level_a);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (level_a !== 8'd98) begin
            errors++;
            $display("FAIL gate_next_step: got %0d, expected 98", level_a);
        end
        rst_a = 1'b1;
    endtask

    // STEP_DIV=256: period p uses the level p-1 latched at its start.
    task automatic test_level_even;
        int h;
        int m;
        logic [7:0] d;
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        en_b  = 1'b1;
        for (int p = 0; p < 130; p++) begin
            d = (p == 0) ? 8'd0 : dmap(8'(p - 1));
            measure_period(1'b1, d, h, m);
            if (p == 1 || p == 65 || p == 129) begin
                checks++;
                if (h !== int'(d)) begin
                    errors++;
                    $display("FAIL even_level_count[level %0d]: got %0d high cycles, expected %0d", p - 1, h, d);
                end
                checks++;
                if (m !== 0) begin
                    errors++;
                    $display("FAIL even_level_contiguous[level %0d]: %0d misplaced, expected 0", p - 1, m);
                end
            end
        end
        checks++;
        if (level_b !== 8'd130) begin
            errors++;
            $display("FAIL even_level_final: got %0d, expected 130", level_b);
        end
        rst_b = 1'b1;
    endtask

    task automatic test_other_leds;
        checks++;
        if (other_bad !== 1'b0) begin
            errors++;
            $display("FAIL other_leds: LED6..LED0 observed nonzero, expected always 0");
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_pwm_duty();
        test_enable_gating();
        test_level_even();
        test_other_leds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
